// File: rtl/svm_det_collect_if.sv
// Bundles the score-in stream, detection readout stream and per-frame results of svm_det_collect.
// slave is the collector's view; master is the view of whoever drives scores and drains detections.
interface svm_det_collect_if #(
  parameter int SW_W  = 11,
  parameter int FEA_W = 12,
  parameter int CNT_W = 11
);
  logic             i_valid;
  logic [SW_W-1:0]  i_sw_id;
  logic [FEA_W-1:0] i_score;
  logic [FEA_W-1:0] thr;

  logic             o_valid;
  logic             o_ready;
  logic [SW_W-1:0]  o_sw_id;
  logic [FEA_W-1:0] o_score;

  logic             frame_done;
  logic [CNT_W-1:0] frm_det_cnt;
  logic             frm_best_valid;
  logic [SW_W-1:0]  frm_best_sw_id;
  logic [FEA_W-1:0] frm_best_score;
  logic             frm_overflow;
  logic             seq_err;

  modport slave (
    input  i_valid, i_sw_id, i_score, thr, o_ready,
    output o_valid, o_sw_id, o_score,
    output frame_done, frm_det_cnt, frm_best_valid, frm_best_sw_id, frm_best_score,
    output frm_overflow, seq_err
  );

  modport master (
    output i_valid, i_sw_id, i_score, thr, o_ready,
    input  o_valid, o_sw_id, o_score,
    input  frame_done, frm_det_cnt, frm_best_valid, frm_best_sw_id, frm_best_score,
    input  frm_overflow, seq_err
  );
endinterface

// File: rtl/svm_det_collect.sv
// Thresholds SVM window scores, queues detections in a FWFT FIFO (push-to-valid latency 1, drops when full
// without a same-cycle pop; no backpressure on the score input) and publishes per-frame count/best/overflow.
module svm_det_collect #(
  parameter int SW_W       = 11,
  parameter int FEA_W      = 12,
  parameter int N_SW       = 1200,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 11
) (
  input logic              clk,
  input logic              rst,
  svm_det_collect_if.slave bus
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [SW_W-1:0] LAST_ID = SW_W'(N_SW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [SW_W-1:0]  sw_id;
    logic [FEA_W-1:0] score;
  } det_t;

  state_e           state_q, state_d;
  logic [SW_W-1:0]  exp_q, exp_d;
  logic [FEA_W-1:0] thr_r_q, thr_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             best_vld_q, best_vld_d;
  logic [SW_W-1:0]  best_id_q, best_id_d;
  logic [FEA_W-1:0] best_score_q, best_score_d;
  logic             ovf_q, ovf_d;
  logic             seq_err_q, seq_err_d;

  logic             frame_done_q;
  logic [CNT_W-1:0] frm_cnt_q;
  logic             frm_best_vld_q;
  logic [SW_W-1:0]  frm_best_id_q;
  logic [FEA_W-1:0] frm_best_score_q;
  logic             frm_ovf_q;

  det_t             mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  det_t             head;

  logic             start, accept, det, frame_end;
  logic             push, pop, full;
  logic [FEA_W-1:0] thr_use;

  assign full = (count_q == FULL_CNT);
  assign pop  = bus.o_valid && bus.o_ready;
  assign push = det && (!full || pop);

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    thr_r_d      = thr_r_q;
    cnt_d        = cnt_q;
    best_vld_d   = best_vld_q;
    best_id_d    = best_id_q;
    best_score_d = best_score_q;
    ovf_d        = ovf_q;
    seq_err_d    = seq_err_q;
    frame_end    = 1'b0;
    det          = 1'b0;
    thr_use      = thr_r_q;

    start  = bus.i_valid && (bus.i_sw_id == '0);
    accept = bus.i_valid && ((state_q == RUN) || start);

    // Index 0 opens a frame from IDLE and also restarts a frame in progress.
    if (start) begin
      thr_use      = bus.thr;
      thr_r_d      = bus.thr;
      cnt_d        = '0;
      best_vld_d   = 1'b0;
      best_id_d    = '0;
      best_score_d = '0;
      ovf_d        = 1'b0;
    end

    if (accept) begin
      if ((state_q == RUN) && !start && (bus.i_sw_id != exp_q)) begin
        seq_err_d = 1'b1;
      end
      exp_d = bus.i_sw_id + 1'b1;
      det   = $signed(bus.i_score) > $signed(thr_use);
      if (bus.i_sw_id == LAST_ID) begin
        frame_end = 1'b1;
        state_d   = IDLE;
      end else begin
        state_d   = RUN;
      end
    end

    if (det) begin
      if (cnt_d != CNT_MAX) begin
        cnt_d = cnt_d + 1'b1;
      end
      if (!best_vld_d || ($signed(bus.i_score) > $signed(best_score_d))) begin
        best_vld_d   = 1'b1;
        best_id_d    = bus.i_sw_id;
        best_score_d = bus.i_score;
      end
      if (full && !pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      exp_q            <= '0;
      thr_r_q          <= '0;
      cnt_q            <= '0;
      best_vld_q       <= 1'b0;
      best_id_q        <= '0;
      best_score_q     <= '0;
      ovf_q            <= 1'b0;
      seq_err_q        <= 1'b0;
      frame_done_q     <= 1'b0;
      frm_cnt_q        <= '0;
      frm_best_vld_q   <= 1'b0;
      frm_best_id_q    <= '0;
      frm_best_score_q <= '0;
      frm_ovf_q        <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      thr_r_q      <= thr_r_d;
      cnt_q        <= cnt_d;
      best_vld_q   <= best_vld_d;
      best_id_q    <= best_id_d;
      best_score_q <= best_score_d;
      ovf_q        <= ovf_d;
      seq_err_q    <= seq_err_d;
      frame_done_q <= frame_end;
      // Published values include the last window's own contribution.
      if (frame_end) begin
        frm_cnt_q        <= cnt_d;
        frm_best_vld_q   <= best_vld_d;
        frm_best_id_q    <= best_id_d;
        frm_best_score_q <= best_score_d;
        frm_ovf_q        <= ovf_d;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{sw_id: bus.i_sw_id, score: bus.i_score};
    end
  end

  // Storage is not reset, so the head is masked to keep the outputs at 0 while empty.
  assign head           = mem_q[rd_ptr_q];
  assign bus.o_valid    = (count_q != '0);
  assign bus.o_sw_id    = bus.o_valid ? head.sw_id : '0;
  assign bus.o_score    = bus.o_valid ? head.score : '0;

  assign bus.frame_done     = frame_done_q;
  assign bus.frm_det_cnt    = frm_cnt_q;
  assign bus.frm_best_valid = frm_best_vld_q;
  assign bus.frm_best_sw_id = frm_best_id_q;
  assign bus.frm_best_score = frm_best_score_q;
  assign bus.frm_overflow   = frm_ovf_q;
  assign bus.seq_err        = seq_err_q;

endmodule

// File: tb/tb_svm_det_collect.sv
// Randomized bench for svm_det_collect against a frame-level reference model (small frame, shallow FIFO).
module tb_svm_det_collect;
  localparam int SW_W  = 11;
  localparam int FEA_W = 12;
  localparam int N_SW  = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  svm_det_collect_if #(.SW_W(SW_W), .FEA_W(FEA_W), .CNT_W(CNT_W)) bus ();

  svm_det_collect #(
    .SW_W(SW_W), .FEA_W(FEA_W), .N_SW(N_SW), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct { int id; int sc; } ent_t;

  ent_t mq[$];
  ent_t fdets[$];
  bit   m_run, m_seq, m_fd, m_fovf;
  int   m_exp, m_thr;
  int   e_cnt, e_best_id, e_best_sc;
  bit   e_best_vld, e_ovf;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    fdets.delete();
    m_run = 0; m_seq = 0; m_fd = 0; m_fovf = 0; m_exp = 0; m_thr = 0;
    e_cnt = 0; e_best_id = 0; e_best_sc = 0; e_best_vld = 0; e_ovf = 0;
  endtask

  task automatic publish();
    int mx;
    e_cnt      = (fdets.size() > CMAX) ? CMAX : fdets.size();
    e_ovf      = m_fovf;
    e_best_vld = (fdets.size() > 0);
    e_best_id  = 0;
    e_best_sc  = 0;
    if (fdets.size() > 0) begin
      mx = fdets[0].sc;
      foreach (fdets[i]) if (fdets[i].sc > mx) mx = fdets[i].sc;
      for (int i = fdets.size() - 1; i >= 0; i--) if (fdets[i].sc == mx) e_best_id = fdets[i].id;
      e_best_sc = mx;
    end
  endtask

  // Effect of one clock edge with the given inputs, from the frame rules.
  task automatic model_step(input bit v, input int id, input int sc, input bit rdy, input int th);
    bit start, acc, det, pop, fe;
    int sz;
    sz    = mq.size();
    pop   = (sz > 0) && rdy;
    start = v && (id == 0);
    acc   = v && (m_run || start);
    det   = 0;
    fe    = 0;
    if (start) begin
      fdets.delete();
      m_fovf = 0;
      m_thr  = th;
    end
    if (acc) begin
      if (m_run && !start && id != m_exp) m_seq = 1;
      det   = sc > m_thr;
      m_exp = id + 1;
      if (id == N_SW - 1) begin fe = 1; m_run = 0; end
      else m_run = 1;
    end
    if (pop) void'(mq.pop_front());
    if (det) begin
      fdets.push_back('{id, sc});
      if (sz < DEPTH || pop) mq.push_back('{id, sc});
      else m_fovf = 1;
    end
    m_fd = fe;
    if (fe) publish();
  endtask

  task automatic check_outputs();
    chk("o_valid", bus.o_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("o_sw_id", bus.o_sw_id, mq[0].id);
      chk("o_score", bus.o_score, mq[0].sc & 32'hFFF);
    end
    chk("frame_done", bus.frame_done, m_fd);
    chk("frm_det_cnt", bus.frm_det_cnt, e_cnt);
    chk("frm_best_valid", bus.frm_best_valid, e_best_vld);
    chk("frm_best_sw_id", bus.frm_best_sw_id, e_best_id);
    chk("frm_best_score", bus.frm_best_score, e_best_sc & 32'hFFF);
    chk("frm_overflow", bus.frm_overflow, e_ovf);
    chk("seq_err", bus.seq_err, m_seq);
  endtask

  task automatic step(input bit v, input int id, input int sc, input bit rdy, input int th);
    @(negedge clk);
    check_outputs();
    rst         = 1'b1;
    bus.i_valid = v;
    bus.i_sw_id = SW_W'(id);
    bus.i_score = FEA_W'(sc);
    bus.thr     = FEA_W'(th);
    bus.o_ready = rdy;
    model_step(v, id, sc, rdy, th);
  endtask

  task automatic reset_step();
    @(negedge clk);
    check_outputs();
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;
    model_reset();
  endtask

  task automatic send(input int id, input int sc, input bit rdy, input int th);
    step(1'b1, id, sc, rdy, th);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 0, 0, rdy, 0);
  endtask

  function automatic int rnd_sc();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic rand_frame(input bit sat, input int rdy_pct, input bit do_rst);
    int id, th_base, th, sc, sent;
    bit restarted;
    id        = 0;
    restarted = 0;
    th_base   = sat ? -2048 : int'($urandom_range(0, 1023)) - 512;
    while (id < N_SW) begin
      th = (sat || $urandom_range(0, 1) == 0) ? th_base : rnd_sc();
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, int'($urandom_range(0, N_SW - 1)), rnd_sc(), $urandom_range(0, 99) < rdy_pct, th);
        continue;
      end
      sent = id;
      if (id > 2 && $urandom_range(0, 19) == 0) sent = (id + int'($urandom_range(1, 3)) > N_SW - 1) ? N_SW - 1 : id + int'($urandom_range(1, 3));
      else if (id > 2 && !restarted && $urandom_range(0, 29) == 0) begin sent = 0; restarted = 1; end
      sc = ($urandom_range(0, 7) == 0) ? m_thr : rnd_sc();
      send(sent, sc, $urandom_range(0, 99) < rdy_pct, th);
      if (do_rst && sent == 7) begin
        reset_step();
        return;
      end
      id = sent + 1;
    end
  endtask

  initial begin
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_sw_id = '0;
    bus.i_score = '0;
    bus.thr     = '0;
    bus.o_ready = 1'b0;
    model_reset();
    reset_step();
    chk("rst_o_sw_id", bus.o_sw_id, 0);
    chk("rst_o_score", bus.o_score, 0);
    reset_step();

    // Basic frame: two detections, zero score is not above thr=0.
    send(0, 'h010, 1, 0); send(1, -'h020, 1, 0); send(2, 0, 1, 0); send(3, 'h100, 1, 0);
    for (int i = 4; i < N_SW; i++) send(i, -'h100, 1, 0);
    idle(1);
    chk("A_frame_done", bus.frame_done, 1);
    chk("A_cnt", bus.frm_det_cnt, 2);
    chk("A_best_id", bus.frm_best_sw_id, 3);
    chk("A_best_sc", bus.frm_best_score, 'h100);
    chk("A_ovf", bus.frm_overflow, 0);
    idle(1);

    // Six detections with the consumer stalled: four kept, overflow flagged.
    for (int i = 0; i < N_SW; i++) send(i, (i < 6) ? 'h040 + i : -'h100, 0, 0);
    idle(0);
    chk("B_cnt", bus.frm_det_cnt, 6);
    chk("B_ovf", bus.frm_overflow, 1);
    repeat (6) idle(1);

    // Full FIFO with a same-cycle pop and push.
    for (int i = 0; i < N_SW; i++) send(i, (i < 5) ? 'h030 + i : -'h100, (i == 4), 0);
    idle(0);
    chk("C_ovf", bus.frm_overflow, 0);
    chk("C_cnt", bus.frm_det_cnt, 5);
    repeat (6) idle(1);

    // Tied best scores and a score equal to the threshold.
    send(0, -1, 1, 'h020); send(1, 'h050, 1, 'h020); send(2, 'h050, 1, 'h020); send(3, 'h020, 1, 'h020);
    for (int i = 4; i < N_SW; i++) send(i, -'h100, 1, 'h020);
    idle(1);
    chk("D_best_id", bus.frm_best_sw_id, 1);
    chk("D_cnt", bus.frm_det_cnt, 2);

    // Restart mid-frame, then an index jump.
    send(0, 'h010, 1, 0); send(1, 'h011, 1, 0); send(0, -'h010, 1, 0); send(1, 'h012, 1, 0);
    send(2, -'h010, 1, 0);
    for (int i = 5; i < N_SW; i++) send(i, -'h100, 1, 0);
    idle(1);
    chk("E_seq_err", bus.seq_err, 1);
    chk("E_cnt", bus.frm_det_cnt, 1);

    // Reset with three entries queued mid-frame.
    for (int i = 0; i < 5; i++) send(i, (i % 2 == 0) ? 'h070 : -'h070, 0, 0);
    reset_step();
    reset_step();
    chk("F_o_valid", bus.o_valid, 0);
    chk("F_cnt", bus.frm_det_cnt, 0);
    chk("F_seq_err", bus.seq_err, 0);
    send(3, 'h100, 1, 0); send(4, 'h100, 1, 0); idle(1);
    chk("F_idle_ignored", bus.o_valid, 0);

    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(0, 3)) send(int'($urandom_range(1, N_SW - 1)), rnd_sc(), 1, 0);
      rand_frame(f % 5 == 2, (f % 3 == 0) ? 20 : 70, f == 17);
      repeat ($urandom_range(1, 4)) idle($urandom_range(0, 1));
    end
    repeat (8) idle(1);
    @(negedge clk);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/svm_det_collect.md
Name: svm_det_collect

Overview:
- Sits directly downstream of the SVM classifier.
- Takes one signed score per slide window (window valid, window index, score), thresholds it, and queues positive windows in a FIFO for readout over a valid/ready handshake.
- Tracks frame boundaries by window index and publishes per-frame results: detection count, best-scoring window and an overflow flag.

Parameters:
- SW_W, 11, slide-window index width.
- FEA_W, 12, score width; two's complement, 4 integer / 8 fractional bits.
- N_SW, 1200, slide windows per frame; last index is N_SW-1.
- FIFO_DEPTH, 16, detection FIFO entries; power of two.
- CNT_W, 11, detection counter width.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous, active-low reset.
- i_valid, input, 1, window score valid; single-cycle strobes, no backpressure.
- i_sw_id, input, SW_W, window index.
- i_score, input, FEA_W, signed SVM score.
- thr, input, FEA_W, signed detection threshold.
- o_valid, output, 1, FIFO head valid.
- o_ready, input, 1, consumer accepts head.
- o_sw_id, output, SW_W, head window index.
- o_score, output, FEA_W, head score.
- frame_done, output, 1, one-cycle pulse when frame results update.
- frm_det_cnt, output, CNT_W, detections in last completed frame.
- frm_best_valid, output, 1, last frame had at least one detection.
- frm_best_sw_id, output, SW_W, index of highest-scoring detection.
- frm_best_score, output, FEA_W, that score.
- frm_overflow, output, 1, last frame dropped at least one detection.
- seq_err, output, 1, sticky out-of-order window index flag; cleared only by reset.

Behaviour:
- Reset (rst=0 at clk edge): FSM to IDLE; FIFO emptied; all outputs 0.
- FSM states: IDLE, RUN.
  - IDLE: i_valid with i_sw_id==0 → RUN. That window is processed. Frame start clears the running count, running best and running overflow, and latches thr into thr_r. Window 0 compares against thr directly.
  - IDLE: i_valid with i_sw_id!=0 is ignored entirely (no push, no count).
  - RUN: expected index exp increments on every accepted window.
    - i_sw_id==exp: process normally.
    - i_sw_id==0: restart frame (same actions as frame start). Partial results are discarded; no frame_done; FIFO not flushed.
    - Any other index: set seq_err, process the window, set exp=i_sw_id+1.
  - RUN: processed window with i_sw_id==N_SW-1 → frame end; go to IDLE.
- Detection: det = processed && $signed(i_score) > $signed(threshold). Equal to the threshold is not a detection.
- Running count: increments on every det, including dropped ones; saturates at 2^CNT_W-1.
- Running best: updated when det and (no best yet, or score strictly greater). Ties keep the earlier window.
- Frame end: in the cycle after the last window, frame_done=1 for one cycle. frm_* registers take the running values, including the last window's contribution. frm_* hold until the next frame end.
- FIFO:
  - First-word-fall-through.
  - Push on det. o_valid rises the cycle after the push (latency 1).
  - o_sw_id/o_score are stable while o_valid=1 and o_ready=0.
  - Pop on o_valid && o_ready.
  - Full and det without pop: entry dropped; running overflow set.
  - Full and det with a same-cycle pop: push accepted, no overflow.
  - Empty: a same-cycle push and pop cannot occur, because o_valid is still 0.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- o_sw_id/o_score are don't-care when o_valid=0; drive 0 from reset until the first push.
- Reset mid-frame: FIFO contents lost; frm_* cleared; no frame_done issued.

Test Plan:
- Frame N_SW=4 (override), thr=0, scores {+0x010, -0x020, 0x000, +0x100}, o_ready=1 → FIFO outputs (0,0x010) then (3,0x100). frame_done one cycle after window 3. frm_det_cnt=2, frm_best_sw_id=3, frm_best_score=0x100, frm_overflow=0.
- o_ready=0, FIFO_DEPTH=4, 6 detections in one frame → 4 entries kept in order, frm_overflow=1, frm_det_cnt=6. Then o_ready=1 drains all 4 with o_valid falling after the 4th pop.
- FIFO full with o_ready=1 and a same-cycle detection → push accepted, no overflow, order preserved.
- Equal best scores 0x050 at windows 1 and 2 → frm_best_sw_id=1. Score == thr → not counted.
- Mid-frame i_sw_id=0 after windows 0..1 → no frame_done, counts restart. Index jump 2→5 → seq_err=1 and frame still ends at N_SW-1.
- rst=0 asserted with 3 entries queued mid-frame → o_valid=0, frm_*=0, next frame starts only at i_sw_id==0.
